// File: rtl/display_arb_pkg.sv
// Shared types and constants for the 7-segment display arbiter.
package display_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_OWN   = 2'd2
   } state_e;

   localparam logic [7:0]  BLANK_PATTERN_DEFAULT = 8'hFF;
   localparam int unsigned HOLD_W  = 8;
   localparam int unsigned BLANK_W = 4;

endpackage

// File: rtl/prio_pick.sv
// Combinational lowest-index-set-bit finder; index 0 has highest priority.
module prio_pick #(
   parameter  int unsigned N_REQ = 4,
   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
)(
   input  logic [N_REQ-1:0] req_i,
   output logic [IDX_W-1:0] idx_c_o,
   output logic             valid_c_o
);

   // Scan high to low so the lowest set index wins last.
   always_comb begin
      idx_c_o = '0;
      for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
         if (req_i[i]) idx_c_o = IDX_W'(i);
      end
   end

   assign valid_c_o = |req_i;

endmodule

// File: rtl/display_arbiter.sv
// Fixed-priority owner of the shared 7-segment pad bus with minimum hold
// and a blanking gap on every owner change.
module display_arbiter
   import display_arb_pkg::*;
#(
   parameter  int unsigned N_REQ         = 4,
   parameter  int unsigned HOLD_CYCLES   = 16,
   parameter  int unsigned BLANK_CYCLES  = 2,
   parameter  logic [7:0]  BLANK_PATTERN = BLANK_PATTERN_DEFAULT,
   localparam int unsigned IDX_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   input  logic [8*N_REQ-1:0]   pattern,
   output logic [N_REQ-1:0]     grant,
   output logic [IDX_W-1:0]     owner_id,
   output logic [7:0]           seg_out,
   output logic                 switching
);

   localparam bit                 HAS_BLANK    = (BLANK_CYCLES != 0);
   localparam logic [BLANK_W-1:0] BLANK_RELOAD = HAS_BLANK ? BLANK_W'(BLANK_CYCLES - 1) : '0;
   localparam logic [HOLD_W-1:0]  HOLD_RELOAD  = HOLD_W'(HOLD_CYCLES);

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     pending_q, pending_d;
   logic [IDX_W-1:0]     owner_q, owner_d;
   logic [BLANK_W-1:0]   blank_cnt_q, blank_cnt_d;
   logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
   logic [N_REQ-1:0]     grant_q, grant_d;
   logic [IDX_W-1:0]     owner_id_q, owner_id_d;
   logic [7:0]           seg_q, seg_d;
   logic                 switching_q, switching_d;

   logic [IDX_W-1:0]     win_idx, pre_idx, switch_tgt;
   logic                 win_vld, pre_vld, switch_go;
   logic [N_REQ-1:0]     lower_mask;

   prio_pick #(.N_REQ(N_REQ)) u_pick_all (
      .req_i     (req),
      .idx_c_o   (win_idx),
      .valid_c_o (win_vld)
   );

   // Only requesters strictly above the current owner may preempt.
   always_comb begin
      lower_mask = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         lower_mask[i] = (IDX_W'(i) < owner_q);
      end
   end

   prio_pick #(.N_REQ(N_REQ)) u_pick_pre (
      .req_i     (req & lower_mask),
      .idx_c_o   (pre_idx),
      .valid_c_o (pre_vld)
   );

   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      owner_d     = owner_q;
      blank_cnt_d = blank_cnt_q;
      hold_cnt_d  = hold_cnt_q;
      switch_go   = 1'b0;
      switch_tgt  = win_idx;

      unique case (state_q)
         ST_IDLE: begin
            hold_cnt_d  = '0;
            blank_cnt_d = '0;
            if (win_vld) switch_go = 1'b1;
         end
         ST_BLANK: begin
            if (!win_vld) begin
               state_d = ST_IDLE;
            end else if (!req[pending_q]) begin
               pending_d   = win_idx;
               blank_cnt_d = BLANK_RELOAD;
            end else if (blank_cnt_q == '0) begin
               state_d    = ST_OWN;
               owner_d    = pending_q;
               hold_cnt_d = HOLD_RELOAD;
            end else begin
               blank_cnt_d = blank_cnt_q - BLANK_W'(1);
            end
         end
         ST_OWN: begin
            if (!req[owner_q]) begin
               if (win_vld) switch_go = 1'b1;
               else         state_d   = ST_IDLE;
            end else if (hold_cnt_q == '0 && pre_vld) begin
               switch_go  = 1'b1;
               switch_tgt = pre_idx;
            end else if (hold_cnt_q != '0) begin
               hold_cnt_d = hold_cnt_q - HOLD_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // With no blanking gap a new owner is granted on the same edge.
      if (switch_go) begin
         pending_d = switch_tgt;
         if (HAS_BLANK) begin
            state_d     = ST_BLANK;
            blank_cnt_d = BLANK_RELOAD;
         end else begin
            state_d    = ST_OWN;
            owner_d    = switch_tgt;
            hold_cnt_d = HOLD_RELOAD;
         end
      end

      grant_d     = '0;
      owner_id_d  = '0;
      seg_d       = BLANK_PATTERN;
      switching_d = (state_d == ST_BLANK);
      if (state_d == ST_OWN) begin
         grant_d    = N_REQ'(1) << owner_d;
         owner_id_d = owner_d;
         seg_d      = pattern[int'(owner_d)*8 +: 8];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         pending_q   <= '0;
         owner_q     <= '0;
         blank_cnt_q <= '0;
         hold_cnt_q  <= '0;
         grant_q     <= '0;
         owner_id_q  <= '0;
         seg_q       <= BLANK_PATTERN;
         switching_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         owner_q     <= owner_d;
         blank_cnt_q <= blank_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         grant_q     <= grant_d;
         owner_id_q  <= owner_id_d;
         seg_q       <= seg_d;
         switching_q <= switching_d;
      end
   end

   assign grant     = grant_q;
   assign owner_id  = owner_id_q;
   assign seg_out   = seg_q;
   assign switching = switching_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench: stimulus queues expected output changes tagged with the
// clock edge that must produce them; a negedge monitor pops and compares.
module tb_display_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [3:0]  req0;
   logic [31:0] pattern;
   logic [3:0]  grant, grant0;
   logic [1:0]  owner_id, owner_id0;
   logic [7:0]  seg_out, seg_out0;
   logic        switching, switching0;

   display_arbiter #(.N_REQ(4), .HOLD_CYCLES(16), .BLANK_CYCLES(2), .BLANK_PATTERN(8'hFF)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .pattern   (pattern),
      .grant     (grant),
      .owner_id  (owner_id),
      .seg_out   (seg_out),
      .switching (switching)
   );

   display_arbiter #(.N_REQ(4), .HOLD_CYCLES(16), .BLANK_CYCLES(0), .BLANK_PATTERN(8'hFF)) u_dut0 (
      .clk       (clk),
      .rst       (rst),
      .req       (req0),
      .pattern   (pattern),
      .grant     (grant0),
      .owner_id  (owner_id0),
      .seg_out   (seg_out0),
      .switching (switching0)
   );

   typedef struct {
      int          e;
      logic [14:0] val;
   } ev_t;

   localparam logic [14:0] V_IDLE  = {4'b0000, 2'd0, 8'hFF, 1'b0};
   localparam logic [14:0] V_BLANK = {4'b0000, 2'd0, 8'hFF, 1'b1};

   ev_t         sb[$];
   ev_t         ev;
   int          edge_n = 0;
   int          n_chk  = 0;
   int          n_fail = 0;
   int          k;
   int          own_e;
   bit          mon_en = 0;
   bit          sw0_seen = 0;
   logic [14:0] last, obs;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int e, input logic [14:0] v);
      ev_t t;
      t.e   = e;
      t.val = v;
      sb.push_back(t);
   endtask

   task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every output change must match the head of the scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         obs = {grant, owner_id, seg_out, switching};
         if (obs !== last) begin
            n_chk++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_change edge %0d: got %h", edge_n, obs);
            end else begin
               ev = sb.pop_front();
               if (obs !== ev.val || edge_n != ev.e) begin
                  n_fail++;
                  $display("FAIL sb_event: got %h at edge %0d, expected %h at edge %0d",
                           obs, edge_n, ev.val, ev.e);
               end
            end
            last = obs;
         end
         while (sb.size() > 0 && sb[0].e < edge_n) begin
            ev = sb.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missing_event: expected %h at edge %0d, still %h", ev.val, ev.e, obs);
         end
      end
   end

   always @(negedge clk) if (!rst && switching0) sw0_seen = 1'b1;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst     = 1'b0;
      req     = 4'b0000;
      req0    = 4'b0000;
      pattern = {8'h44, 8'hA5, 8'h22, 8'h11};
      #1 rst  = 1'b1;

      // Reset holds everything blank even with all requests asserted.
      req = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("reset_hold", {grant, owner_id, seg_out, switching}, V_IDLE);
      end
      chk("reset_hold_b0", {grant0, owner_id0, seg_out0, switching0}, V_IDLE);

      last   = V_IDLE;
      rst    = 1'b0;
      mon_en = 1'b1;
      k = edge_n + 1;
      push(k,     V_BLANK);
      push(k + 2, {4'b0001, 2'd0, 8'h11, 1'b0});
      cyc(3);
      req = 4'b0000;
      k = edge_n + 1;
      push(k, V_IDLE);
      cyc(2);

      // Single request, then live pattern tracking.
      req = 4'b0100;
      k = edge_n + 1;
      push(k,     V_BLANK);
      push(k + 2, {4'b0100, 2'd2, 8'hA5, 1'b0});
      cyc(3);
      own_e = edge_n;
      pattern[23:16] = 8'h3C;
      push(edge_n + 1, {4'b0100, 2'd2, 8'h3C, 1'b0});
      cyc(1);

      // Higher-priority request waits out the hold.
      req = 4'b0101;
      push(own_e + 17, V_BLANK);
      push(own_e + 19, {4'b0001, 2'd0, 8'h11, 1'b0});
      cyc(own_e + 19 - edge_n);

      // Lower priority never preempts; release hands over.
      req = 4'b0010;
      k = edge_n + 1;
      push(k,     V_BLANK);
      push(k + 2, {4'b0010, 2'd1, 8'h22, 1'b0});
      cyc(3);
      req = 4'b1010;
      cyc(100);
      req = 4'b1000;
      k = edge_n + 1;
      push(k,     V_BLANK);
      push(k + 2, {4'b1000, 2'd3, 8'h44, 1'b0});
      cyc(3);

      // Early release during hold, then retarget mid-blank.
      req = 4'b0001;
      k = edge_n + 1;
      push(k,     V_BLANK);
      push(k + 2, {4'b0001, 2'd0, 8'h11, 1'b0});
      cyc(3);
      req = 4'b1100;
      k = edge_n + 1;
      push(k, V_BLANK);
      cyc(1);
      req = 4'b1000;
      push(k + 3, {4'b1000, 2'd3, 8'h44, 1'b0});
      cyc(3);

      // All requests vanish during blank.
      req = 4'b0100;
      k = edge_n + 1;
      push(k, V_BLANK);
      cyc(1);
      req = 4'b0000;
      push(k + 1, V_IDLE);
      cyc(3);

      // Asynchronous reset mid-ownership clears outputs immediately.
      req = 4'b0010;
      k = edge_n + 1;
      push(k,     V_BLANK);
      push(k + 2, {4'b0010, 2'd1, 8'h22, 1'b0});
      cyc(4);
      #2;
      mon_en = 1'b0;
      rst    = 1'b1;
      #1;
      chk("async_reset", {grant, owner_id, seg_out, switching}, V_IDLE);
      req = 4'b0000;
      cyc(2);
      chk("async_reset_hold", {grant, owner_id, seg_out, switching}, V_IDLE);
      rst    = 1'b0;
      last   = V_IDLE;
      mon_en = 1'b1;
      cyc(3);

      // Zero-blank build: grant on the sampling edge, direct handover.
      chk("b0_idle", {grant0, owner_id0, seg_out0, switching0}, V_IDLE);
      req0 = 4'b0010;
      cyc(1);
      chk("b0_grant", {grant0, owner_id0, seg_out0, switching0}, {4'b0010, 2'd1, 8'h22, 1'b0});
      req0 = 4'b0001;
      cyc(1);
      chk("b0_handover", {grant0, owner_id0, seg_out0, switching0}, {4'b0001, 2'd0, 8'h11, 1'b0});
      req0 = 4'b0000;
      cyc(1);
      chk("b0_release", {grant0, owner_id0, seg_out0, switching0}, V_IDLE);
      cyc(2);
      chk("b0_no_switching", {14'd0, sw0_seen}, 15'd0);

      while (sb.size() > 0) begin
         ev = sb.pop_front();
         n_chk++;
         n_fail++;
         $display("FAIL leftover_event: expected %h at edge %0d", ev.val, ev.e);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares the single 7-segment pad bus ({dp,seg[6:0]}) between several display requesters: mole target, score digits, high-score, attract animation.
- Uses strict fixed priority, with a minimum ownership hold and a forced blanking gap on every owner change to avoid ghosting.
- Sits between the game-side pattern generators and the top-level output pipeline; the top level drives its registered output to uo_out.

Parameters:
N_REQ, 4, number of requesters; index 0 is highest priority.
HOLD_CYCLES, 16, minimum OWN cycles before a higher-priority requester may preempt (0..255).
BLANK_CYCLES, 2, blank cycles inserted before every new grant (0..15).
BLANK_PATTERN, 8'hFF, {dp,seg} value that drives all segments off (active-low).

Ports:
clk  in  1  single system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
req  in  N_REQ  per-requester display request, level-sensitive.
pattern  in  8*N_REQ  flattened {dp,seg} per requester; requester i occupies bits [8i+7:8i].
grant  out  N_REQ  one-hot current owner, registered; all-zero when no owner.
owner_id  out  $clog2(N_REQ)  index of current owner; 0 when grant is zero.
seg_out  out  8  registered {dp,seg} to the pad pipeline.
switching  out  1  high while in BLANK state.

Behaviour:
- Reset (async, rst=1): state=IDLE, grant=0, owner_id=0, seg_out=BLANK_PATTERN, switching=0, counters=0. Asserting rst mid-operation forces these values immediately.
- Winner = lowest-index set bit of the qualifying request vector.
- All outputs are registered from the next-state, so grant, owner_id and seg_out change on the same edge.
- IDLE:
  - Outputs are blank.
  - If req!=0 at edge k: latch pending=winner(req).
  - BLANK_CYCLES>0: go to BLANK with blank_cnt=BLANK_CYCLES-1.
  - BLANK_CYCLES=0: go directly to OWN.
- BLANK:
  - grant=0, seg_out=BLANK_PATTERN, switching=1.
  - req[pending] dropped and req!=0: pending=winner(req), blank_cnt reloads.
  - req==0: go to IDLE.
  - Otherwise blank_cnt==0: go to OWN with owner=pending, hold_cnt=HOLD_CYCLES.
  - Otherwise decrement blank_cnt.
- Grant latency: a request sampled at edge k shows grant in the cycle after edge k+BLANK_CYCLES.
- OWN:
  - grant=onehot(owner).
  - seg_out updates every cycle to pattern[owner] sampled at that edge (1-cycle latency, live pattern tracking).
  - hold_cnt decrements toward 0 and saturates at 0.
  - Release: req[owner]==0 releases immediately, ignoring hold. If other req are present, go to BLANK with the new winner; otherwise go to IDLE.
  - Preempt: only when hold_cnt==0 and some req[j] with j<owner is set. Go to BLANK with pending=winner.
  - Lower-priority requests never preempt. Strict priority; starvation of low-priority requesters is by design.
  - Minimum ownership under contention is HOLD_CYCLES+1 cycles.
- Simultaneous owner drop and new higher-priority request: treated as release; winner is taken from the remaining req.
- grant is never multi-hot. grant!=0 only in OWN.
- pattern values are don't-care for non-owners.

Decomposition:
- Package display_arb_pkg holds:
  - state enum {IDLE, BLANK, OWN}, 2-bit;
  - BLANK_PATTERN default;
  - counter width constants (HOLD_W=8, BLANK_W=4).
- One natural sub-module, prio_pick: combinational lowest-index-set-bit finder, N_REQ parameterised, outputs index and valid. Instantiated twice:
  - on req, for the general winner;
  - on req masked to indices below owner, for preemption.
- All state and counters live in display_arbiter (about 180 lines).

Test Plan:
1. Reset: rst=1 with req=4'b1111 -> grant=0, seg_out=8'hFF, owner_id=0 held while rst=1. After release, grant=4'b0001 two cycles later (BLANK_CYCLES=2).
2. Single request: req=4'b0100, pattern[2]=8'hA5 sampled at edge k -> switching=1 for 2 cycles, then grant=4'b0100, owner_id=2, seg_out=8'hA5. Change pattern[2] to 8'h3C -> seg_out=8'h3C one cycle later.
3. Preempt with hold: owner 2 granted; req[0] rises on OWN cycle 3 (HOLD=16) -> grant stays 4'b0100 through OWN cycle 17, then 2 blank cycles, then grant=4'b0001.
4. No low-priority preempt: owner 1; req[3] set for 100 cycles -> grant stays 4'b0010. Drop req[1] -> blank 2 cycles -> grant=4'b1000.
5. Early release and blank retarget: owner 0 drops during hold -> immediate BLANK. req[2] drops mid-BLANK while req[3] is set -> blank_cnt reloads, grant=4'b1000 2 cycles later. All req drop in BLANK -> IDLE with seg_out=8'hFF.
6. BLANK_CYCLES=0 build: req=4'b0010 at edge k -> grant=4'b0010 the cycle after edge k; switching never asserts.
